// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell and a carry/borrow flop, LSB first.
// Optional signed-overflow flag is built only when SERIAL_ADDSUB_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0   // 0 = add, 1 = subtract, 2 = runtime select via op
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             sub_q;

  logic             accept;
  logic             last;
  logic             eff_sub;
  logic             a_k, b_k;
  logic             d;
  logic             c_add, c_sub, c_nxt;
  logic [WIDTH-1:0] res_nxt;

  // start is only honoured outside RUN, so a mid-operation request never disturbs the operands.
  assign accept  = start && (state != RUN);
  assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign eff_sub = (MODE == 2) ? op : (MODE == 1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ------------------------------------------------------ bit-serial cell
  always_comb begin
    a_k     = sa[0];
    b_k     = sb[0];
    d       = a_k ^ b_k ^ c;
    c_add   = (a_k & b_k) | (c & (a_k ^ b_k));
    c_sub   = (~a_k & b_k) | (c & ~(a_k ^ b_k));
    c_nxt   = sub_q ? c_sub : c_add;
    res_nxt = {d, res_sh};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res_sh <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sub_q  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      c     <= cin;
      cnt   <= '0;
      sub_q <= eff_sub;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      c      <= c_nxt;
      cnt    <= cnt + CW'(1);
      res_sh <= res_nxt[WIDTH-1:1];
      // Visible outputs move only on the MSB edge; they hold through any later RUN.
      if (last) begin
        result <= res_nxt;
        cout   <= c_nxt;
      end
    end
  end

  // ------------------------------------------------------ signed overflow
`ifdef SERIAL_ADDSUB_OVF_EN
  logic c_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      // Carry/borrow leaving bit WIDTH-2 is the one entering the MSB.
      if (cnt == CW'(WIDTH - 2)) c_msb <= c_nxt;
      if (last)                  ovf   <= c_msb ^ c_nxt;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: add-only, subtract-only and runtime-select instances
// share one stimulus stream and are compared against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_addsub;

  localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } obs_t;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;

  logic [2:0]   busy_v, done_v, cout_v, ovf_v;
  logic [W-1:0] res_v [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_addsub #(.WIDTH(W), .MODE(0)) u_add (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_addsub #(.WIDTH(W), .MODE(1)) u_sub (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_addsub #(.WIDTH(W), .MODE(2)) u_rt (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  function automatic obs_t get_obs(input int i);
    get_obs = {res_v[i], cout_v[i], ovf_v[i]};
  endfunction

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic obs_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sub);
    obs_t r;
    int   full;
    int   s;
    int   sx;
    int   sy;
    sx = $signed(x);
    sy = $signed(y);
    if (sub) begin
      full   = int'(x) - int'(y) - int'(ci);
      s      = sx - sy - int'(ci);
      r.cout = (full < 0);
    end else begin
      full   = int'(x) + int'(y) + int'(ci);
      s      = sx + sy + int'(ci);
      r.cout = (full > (2 ** W) - 1);
    end
    r.res = full[W-1:0];
    r.ovf = OVF_ON && ((s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1))));
    return r;
  endfunction

  // Issues one operation (start is driven now, accepted at the next rising edge) and
  // watches it to completion, reporting timing and whether outputs held during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic top, output obs_t o_add, output obs_t o_sub, output obs_t o_rt,
                        output int lat, output int busy_cycles, output logic held, output int done_at);
    obs_t pre [3];
    for (int i = 0; i < 3; i++) pre[i] = get_obs(i);
    a = ta; b = tb_v; cin = tcin; op = top; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_cycles = 0; held = 1'b1; done_at = -1;
    o_add = '0; o_sub = '0; o_rt = '0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (busy_v[2]) busy_cycles++;
      if ((busy_v & done_v) != 3'b000) held = 1'b0;
      if (done_v[2]) begin
        lat     = j;
        done_at = cyc;
        o_add   = get_obs(0);
        o_sub   = get_obs(1);
        o_rt    = get_obs(2);
        break;
      end
      for (int i = 0; i < 3; i++) if (get_obs(i) !== pre[i]) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], get_obs(i)} !== '0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b res=%h cout=%b ovf=%b, want all 0",
                 i, busy_v[i], done_v[i], res_v[i], cout_v[i], ovf_v[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    obs_t oa, os, orr; int lat, bc, dat; logic held;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if (lat !== W) begin n_err++; $display("FAIL add_wrap_latency: got %0d, want %0d", lat, W); end
    n_cmp++;
    if (bc !== W) begin n_err++; $display("FAIL add_wrap_busy_cycles: got %0d, want %0d", bc, W); end
    n_cmp++;
    if (oa !== {8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_wrap: got %h/%b/%b, want 00/1/0", oa.res, oa.cout, oa.ovf);
    end
  endtask

  task automatic test_sub_borrow();
    obs_t oa, os, orr; int lat, bc, dat; logic held;
    run_op(8'h00, 8'h01, 1'b0, 1'b1, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if (os !== {8'hFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow_0m1: got %h/%b/%b, want ff/1/0", os.res, os.cout, os.ovf);
    end
    run_op(8'h05, 8'h03, 1'b1, 1'b1, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if (os !== {8'h01, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow_5m3m1: got %h/%b/%b, want 01/0/0", os.res, os.cout, os.ovf);
    end
  endtask

  task automatic test_overflow();
    obs_t oa, os, orr; int lat, bc, dat; logic held;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if (oa !== {8'h80, 1'b0, OVF_ON}) begin
      n_err++;
      $display("FAIL ovf_add: got %h/%b/%b, want 80/0/%b", oa.res, oa.cout, oa.ovf, OVF_ON);
    end
    run_op(8'h80, 8'h01, 1'b0, 1'b1, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if (os !== {8'h7F, 1'b0, OVF_ON}) begin
      n_err++;
      $display("FAIL ovf_sub: got %h/%b/%b, want 7f/0/%b", os.res, os.cout, os.ovf, OVF_ON);
    end
  endtask

  task automatic test_back_to_back();
    obs_t oa, os, o1, o2; int lat1, lat2, bc, d1, d2; logic h1, h2;
    repeat (3) @(negedge clk);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, oa, os, o1, lat1, bc, h1, d1);
    run_op(8'h50, 8'h20, 1'b0, 1'b1, oa, os, o2, lat2, bc, h2, d2);
    n_cmp++;
    if (o1.res !== 8'h46) begin n_err++; $display("FAIL b2b_first: got %h, want 46", o1.res); end
    n_cmp++;
    if (o2.res !== 8'h30) begin n_err++; $display("FAIL b2b_second: got %h, want 30", o2.res); end
    n_cmp++;
    if (d2 - d1 !== W + 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles, want %0d", d2 - d1, W + 1);
    end
    n_cmp++;
    if ((h1 && h2) !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_hold: got held=%b/%b, want 1/1", h1, h2);
    end
  endtask

  task automatic test_random();
    obs_t oa, os, orr, ea, es, er;
    int lat, bc, dat;
    logic held;
    logic [W-1:0] ra, rb;
    logic rc, ro;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); ro = 1'($urandom);
      ea = model(ra, rb, rc, 1'b0);
      es = model(ra, rb, rc, 1'b1);
      er = model(ra, rb, rc, ro);
      run_op(ra, rb, rc, ro, oa, os, orr, lat, bc, held, dat);
      n_cmp++;
      if (oa !== ea) begin
        n_err++;
        $display("FAIL rand_add %h+%h+%b: got %h/%b/%b, want %h/%b/%b",
                 ra, rb, rc, oa.res, oa.cout, oa.ovf, ea.res, ea.cout, ea.ovf);
      end
      n_cmp++;
      if (os !== es) begin
        n_err++;
        $display("FAIL rand_sub %h-%h-%b: got %h/%b/%b, want %h/%b/%b",
                 ra, rb, rc, os.res, os.cout, os.ovf, es.res, es.cout, es.ovf);
      end
      n_cmp++;
      if (orr !== er) begin
        n_err++;
        $display("FAIL rand_rt op=%b %h,%h,%b: got %h/%b/%b, want %h/%b/%b",
                 ro, ra, rb, rc, orr.res, orr.cout, orr.ovf, er.res, er.cout, er.ovf);
      end
      n_cmp++;
      if ({lat, bc, 31'(held)} !== {W, W, 31'(1)}) begin
        n_err++;
        $display("FAIL rand_timing: got lat=%0d busy=%0d held=%b, want %0d/%0d/1", lat, bc, held, W, W);
      end
    end
  endtask

  task automatic test_ignore_start();
    obs_t exp_rt;
    int   e0, done_cnt, first_done;
    exp_rt = model(8'h21, 8'h13, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'h21; b = 8'h13; cin = 1'b0; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; e0 = cyc;
    repeat (2) @(posedge clk);
    #1 a = 8'hAA; b = 8'h55; cin = 1'b1; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; first_done = -1;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done_v[2]) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc - e0;
      end
    end
    n_cmp++;
    if (first_done !== W) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d, want %0d", first_done, W);
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d, want 1", done_cnt); end
    n_cmp++;
    if (get_obs(2) !== exp_rt) begin
      n_err++;
      $display("FAIL ignore_result: got %h/%b/%b, want %h/%b/%b",
               res_v[2], cout_v[2], ovf_v[2], exp_rt.res, exp_rt.cout, exp_rt.ovf);
    end
  endtask

  task automatic test_abort();
    obs_t oa, os, orr;
    int   lat, bc, dat, stray;
    logic held;
    a = 8'hC3; b = 8'h5A; cin = 1'b1; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], get_obs(i)} !== '0) begin
        n_err++;
        $display("FAIL abort_clear[%0d]: got busy=%b done=%b res=%h cout=%b ovf=%b, want all 0",
                 i, busy_v[i], done_v[i], res_v[i], cout_v[i], ovf_v[i]);
      end
    end
    stray = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (j == 2) rst = 1'b0;
      if ((busy_v | done_v) != 3'b000) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_err++; $display("FAIL abort_idle: got %0d active cycles, want 0", stray); end
    run_op(8'h33, 8'h11, 1'b0, 1'b1, oa, os, orr, lat, bc, held, dat);
    n_cmp++;
    if ({orr.res, lat} !== {8'h22, W}) begin
      n_err++;
      $display("FAIL abort_recover: got %h lat=%0d, want 22 lat=%0d", orr.res, lat, W);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_borrow();
    test_overflow();
    test_back_to_back();
    test_random();
    test_ignore_start();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, parametrised adder/subtractor: latches two WIDTH-bit operands on `start`, then processes one bit per clock, LSB first, through a single full-adder/full-subtractor cell and a carry/borrow flop. It trades latency for area and supersedes the single-bit adder/subtractor cell wherever multi-bit arithmetic is needed at low gate count. The operation is fixed at elaboration or selected per transaction. A one-cycle `done` pulse signals completion.

## Interface
- `WIDTH`, default 8: operand/result width; legal range ≥ 2.
- `MODE`, default 0: 0 = add only, 1 = subtract only, 2 = runtime select via `op`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  1  0 = add, 1 = subtract; sampled with `start`; ignored unless MODE=2.
- `a`  in  WIDTH  operand A (minuend for subtract); sampled with `start`.
- `b`  in  WIDTH  operand B (subtrahend for subtract); sampled with `start`.
- `cin`  in  1  carry-in (add) or borrow-in (subtract); sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  sum or difference; registered; held between completions.
- `cout`  out  1  carry-out (add) or borrow-out (subtract); registered.
- `ovf`  out  1  signed two's-complement overflow; registered (see Configuration).

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → RUN on `start`, otherwise DONE → IDLE.
- **On accept:**
  - Load `a` and `b` into shift registers.
  - Load `cin` into the carry/borrow flop and clear the bit counter to 0.
  - Latch the effective op: MODE 0 → add, MODE 1 → sub, MODE 2 → `op`.
- **Each RUN cycle, bit k (LSB first):**
  - Output bit: d = a_k ^ b_k ^ c.
  - Add carry: c' = a_k&b_k | c&(a_k^b_k).
  - Subtract borrow: c' = ~a_k&b_k | c&~(a_k^b_k).
  - d shifts into the internal result register from the MSB side; the counter increments.
- **Arithmetic:**
  - Add: {`cout`,`result`} = a + b + cin, computed to WIDTH+1 bits.
  - Subtract: `result` = (a − b − cin) mod 2^WIDTH; `cout` = 1 iff a < b + cin (unsigned).
  - `ovf` = (carry/borrow into bit WIDTH-1) XOR (carry/borrow out of bit WIDTH-1).
- **Output update:** `result`, `cout` and `ovf` change only on the edge that processes bit WIDTH-1. They are stable at all other times, including during a subsequent RUN.
- **`start` during RUN:** ignored; no queuing, operands unaffected.
- **Reset:** any state → IDLE. All outputs, shift registers, counter and carry flop clear to 0. A reset during RUN aborts the operation; no `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0.
- Let E0 be the edge that samples `start`.
  - `busy` is high from E0 to E0+WIDTH.
  - Bit k is processed at edge E0+1+k.
  - Outputs update and `done` rises at E0+WIDTH; `done` falls at E0+WIDTH+1.
- Latency is WIDTH cycles from accept to `done`.
- Back-to-back: `start` held high in the DONE cycle is accepted at E0+WIDTH+1, giving a throughput of one operation per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Configuration
- Macro `SERIAL_ADDSUB_OVF_EN`.
- **Defined:**
  - One extra flop holds the carry/borrow into the MSB.
  - `ovf` is computed as specified above.
- **Undefined:**
  - The extra flop and the XOR are removed.
  - The `ovf` port remains in the interface and is tied to constant 0.
- All other behaviour is identical in both builds.

## Test plan
- **Add wrap:** WIDTH=8, MODE=0, a=0xFF, b=0x01, cin=0 → `done` exactly 8 cycles after accept; `result`=0x00, `cout`=1, `ovf`=0.
- **Subtract borrow:** MODE=1, a=0x00, b=0x01, cin=0 → `result`=0xFF, `cout`=1, `ovf`=0. With a=0x05, b=0x03, cin=1 → `result`=0x01, `cout`=0.
- **Overflow (macro defined):**
  - Add 0x7F+0x01 → 0x80, `ovf`=1, `cout`=0.
  - Sub 0x80−0x01 → 0x7F, `ovf`=1, `cout`=0.
  - With the macro undefined, `ovf`=0 for both.
- **Runtime op, back-to-back:** MODE=2.
  - Accept add 0x12+0x34, then hold `start` in the DONE cycle with `op`=1 and a=0x50, b=0x20.
  - Expect 0x46 then 0x30; the second `done` arrives 9 cycles after the first.
- **Ignore and abort:**
  - Pulse `start` with new operands at RUN cycle 2 → first result unchanged, no extra `done`.
  - Assert `rst` at RUN cycle 3 → all outputs 0 immediately, state IDLE, no `done`.
